bridge_tx: RTL
==============

// Module: bridge_tx
// PURPOSE
//  Bus-to-UART response stage; consumes read responses from the last bus core (rdata_i/rw_i/valid_i).
//  Each read response becomes the 7-byte ASCII message "M" + 4 uppercase hex digits + CR + LF.
//  The message is serialised 8N1 on tx. Write acknowledgements produce no output.
// PARAMETERS
//  CLOCKS_PER_BAUD  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  rdata_i     in   16  read data from bus
//  rw_i        in   1   1 = write ack (ignored), 0 = read response
//  valid_i     in   1   bus beat valid, single-cycle strobe, no backpressure
//  tx          out  1   UART serial out, idle high
//  busy_o      out  1   high while a message is being sent or one is pending
//  overflow_o  out  1   sticky: a read response was dropped
// BEHAVIOUR
//  Reset values: tx=1, busy_o=0, overflow_o=0; FSM=IDLE, pending slot empty, counters 0.
//  Accept: a read beat (valid_i & ~rw_i) is captured on the posedge where it is sampled.
//   - FSM IDLE: the beat loads the active register; the start bit appears on tx from the next cycle.
//     Latency from valid_i to tx falling is 1 clk.
//   - FSM busy, pending slot empty: the beat is stored in the pending slot.
//   - FSM busy, pending slot full: the beat is dropped and overflow_o sets to 1 (stays 1 until rst).
//   - A write beat (valid_i & rw_i) or valid_i=0 has no effect.
//  Message bytes, in order: 0x4D 'M', hex(d[15:12]), hex(d[11:8]), hex(d[7:4]), hex(d[3:0]), 0x0D, 0x0A.
//   hex(n) = 0x30+n for n<10, 0x41+(n-10) for n>=10 (uppercase).
//  Byte frame: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLOCKS_PER_BAUD cycles.
//   Frame length is 10*CLOCKS_PER_BAUD cycles. There is no idle gap between the 7 bytes.
//   A full message takes 70*CLOCKS_PER_BAUD cycles.
//  FSM states: IDLE -> SEND (byte index 0..6) -> on the last stop bit end:
//   - pending full: promote pending to active, clear pending, go to SEND index 0.
//     The next start bit follows on the immediately next cycle (no gap).
//   - else: go to IDLE.
//  Simultaneous events:
//   - A read beat arriving on the same cycle the last stop bit ends goes to the pending slot.
//     It is promoted on that same edge, and the slot then reads empty.
//   - If the slot was already full on that cycle, the old pending is promoted and the new beat
//     becomes pending; nothing is dropped.
//  busy_o = (FSM != IDLE) | pending full; registered; low the cycle after the last stop bit
//   when nothing is pending.
//  Baud counter counts 0..CLOCKS_PER_BAUD-1 with width $clog2(CLOCKS_PER_BAUD); wraps to 0 per bit.
//  Bit index counts 0..9 per byte; byte index counts 0..6 per message.
//  Reset mid-message: tx returns to 1 on the next cycle; active and pending data are discarded;
//   a partial byte is never completed.
// STRUCTURE
//  Shared package bridge_pkg:
//   - constants ASCII_M=8'h4D, ASCII_CR=8'h0D, ASCII_LF=8'h0A, MSG_LEN=7
//   - function hex_to_ascii(input [3:0]) -> [7:0]
//   - FSM state typedef {IDLE, SEND}
//  Sub-module uart_tx (byte serialiser): ports clk, rst, data_i[7:0], start_i, busy_o, done_o, tx.
//   bridge_tx holds the message FSM, the active and pending registers, and overflow.
// TESTING (CLOCKS_PER_BAUD=4 in bench)
//  1 Read 0xBEEF -> tx decodes 4D 42 45 45 46 0D 0A; tx low 1 clk after valid_i; busy_o low after 280 clks.
//  2 Write beat rw_i=1, rdata_i=0x1234 -> tx stays 1 and busy_o stays 0 for 400 clks.
//  3 Reads 0x0009 then 0xA0F1, the second 50 clks later -> "M0009\r\n" then "MA0F1\r\n"
//    back-to-back (no gap); overflow_o=0.
//  4 Three reads within 10 clks -> first two messages are sent; the third is dropped; overflow_o=1 until rst.
//  5 rst asserted 100 clks into "M1234" -> tx=1 and busy_o=0 the next clk; a later read 0x5678
//    yields a clean "M5678\r\n".
//  6 Read beat coincident with the final stop-bit cycle -> its message starts on the next clk; no byte lost.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared constants, FSM state type and ASCII helpers
// for the bus-to-UART response bridge.
package bridge_pkg;

  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int         MSG_LEN  = 7;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Uppercase hex digit; 'A'..'F' is 0x37 + n
  function automatic logic [7:0] hex_to_ascii(
    input logic [3:0] n
  );
    logic [7:0] v;
    v = {4'h0, n};
    if (n < 4'd10) begin
      hex_to_ascii = 8'h30 + v;
    end else begin
      hex_to_ascii = 8'h37 + v;
    end
  endfunction

  // Byte idx of the "Mxxxx\r\n" message for data d
  function automatic logic [7:0] msg_byte(
    input logic [15:0] d,
    input logic [2:0]  idx
  );
    case (idx)
      3'd0:    msg_byte = ASCII_M;
      3'd1:    msg_byte = hex_to_ascii(d[15:12]);
      3'd2:    msg_byte = hex_to_ascii(d[11:8]);
      3'd3:    msg_byte = hex_to_ascii(d[7:4]);
      3'd4:    msg_byte = hex_to_ascii(d[3:0]);
      3'd5:    msg_byte = ASCII_CR;
      default: msg_byte = ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/bridge_tx_uart_tx.sv
// 8N1 byte serialiser. A start on the final stop-bit
// cycle chains the next frame with no idle gap.
module uart_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLOCKS_PER_BAUD - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic          bit_end;

  assign bit_end = busy_o & (baud_cnt == BAUD_LAST);
  assign done_o  = bit_end & (bit_idx == 4'd9);
  assign tx      = frame[0];

  // Frame shifter, bit counter and baud counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame    <= '1;
    end else if (start_i) begin
      busy_o   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame    <= {1'b1, data_i, 1'b0};
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy_o  <= 1'b0;
        bit_idx <= '0;
        frame   <= '1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        frame   <= {1'b1, frame[9:1]};
      end
    end else if (busy_o) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bridge_tx.sv
// Turns bus read responses into "Mxxxx\r\n" UART
// messages, with one pending slot and sticky overflow.
module bridge_tx
  import bridge_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        tx,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam logic [2:0] LAST_BYTE = 3'(MSG_LEN - 1);

  state_t      state, state_n;
  logic [2:0]  byte_idx, byte_idx_n;
  logic [15:0] active, active_n;
  logic [15:0] pending, pending_n;
  logic        pend_full, pend_full_n;
  logic        overflow_n;
  logic        busy_n;
  logic        start;
  logic [7:0]  tx_byte;
  logic        ser_busy;
  logic        ser_done;
  logic        rd;
  logic        last;

  assign rd   = valid_i & ~rw_i;
  assign last = ser_done & (byte_idx == LAST_BYTE);

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .data_i (tx_byte),
    .start_i(start),
    .busy_o (ser_busy),
    .done_o (ser_done),
    .tx     (tx)
  );

  // Message FSM state and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      active     <= active_n;
      pending    <= pending_n;
      pend_full  <= pend_full_n;
      overflow_o <= overflow_n;
      busy_o     <= busy_n;
    end
  end

  // Next state: accept, queue, drop, chain bytes
  always_comb begin
    state_n     = state;
    byte_idx_n  = byte_idx;
    active_n    = active;
    pending_n   = pending;
    pend_full_n = pend_full;
    overflow_n  = overflow_o;
    start       = 1'b0;
    tx_byte     = ASCII_M;
    unique case (state)
      IDLE: begin
        if (rd & ~ser_busy) begin
          active_n   = rdata_i;
          byte_idx_n = '0;
          start      = 1'b1;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (last) begin
          if (pend_full) begin
            active_n    = pending;
            byte_idx_n  = '0;
            start       = 1'b1;
            pend_full_n = rd;
            if (rd) begin
              pending_n = rdata_i;
            end
          end else if (rd) begin
            active_n   = rdata_i;
            byte_idx_n = '0;
            start      = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (ser_done) begin
            byte_idx_n = byte_idx + 3'd1;
            start      = 1'b1;
            tx_byte    = msg_byte(active, byte_idx + 3'd1);
          end
          if (rd) begin
            if (pend_full) begin
              overflow_n = 1'b1;
            end else begin
              pending_n   = rdata_i;
              pend_full_n = 1'b1;
            end
          end
        end
      end
    endcase
    busy_n = (state_n != IDLE) | pend_full_n;
  end

endmodule
